noc_packet_arbiter: RTL and testbench
=====================================

Name: noc_packet_arbiter

Overview:
- Shares one LISNoC link (single virtual channel) between NUM_PORTS flit sources, e.g. a compute tile's NA and a DMA engine feeding one router input.
- Arbitration is packet-atomic round-robin: once a HEADER is accepted, the link stays with that source until its LAST flit.
- Output is a registered valid/ready stage with 1-cycle latency and full throughput.

Parameters:
- FLIT_DATA_WIDTH, 32, payload bits per flit.
- FLIT_TYPE_WIDTH, 2, type bits; FLIT_WIDTH = FLIT_DATA_WIDTH + FLIT_TYPE_WIDTH (34).
- NUM_PORTS, 3, number of requesters (2..8).

Ports:
- clk  in  1  block clock
- rst  in  1  asynchronous, active-low reset
- in_flit  in  NUM_PORTS*FLIT_WIDTH  requester flits; port i at [i*FLIT_WIDTH +: FLIT_WIDTH]
- in_valid  in  NUM_PORTS  per-requester flit valid
- in_ready  out  NUM_PORTS  per-requester accept
- out_flit  out  FLIT_WIDTH  flit to NoC
- out_valid  out  1  out_flit valid
- out_ready  in  1  NoC accepts out_flit
- grant  out  NUM_PORTS  one-hot owner of a locked packet, 0 when unlocked
- proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Flit type is flit[FLIT_WIDTH-1 -: 2]:
  - 01 HEADER, 11 SINGLE, 00 PAYLOAD, 10 LAST.
- Reset (rst=0, asynchronous):
  - out_valid=0, out_flit=0, grant=0, proto_err=0, state=IDLE, rr_ptr=0.
  - in_ready=0 while rst=0.
- Output register:
  - load_en = !out_valid || out_ready.
  - A transfer from port i happens when in_valid[i] && in_ready[i]; it loads out_flit and sets out_valid=1 on the next edge.
  - If out_ready=1 and no transfer occurs, out_valid clears.
  - out_flit holds its value while out_valid=1 && out_ready=0.
- State IDLE:
  - sel = first index j with in_valid[j]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_PORTS.
  - in_ready = onehot(sel) & {NUM_PORTS{load_en}}, computed combinationally, same cycle.
  - No valid input means in_ready=0.
  - Accepted HEADER: go to LOCKED, grant=onehot(sel).
  - Accepted SINGLE: stay IDLE, rr_ptr = (sel+1) mod NUM_PORTS.
  - Accepted PAYLOAD or LAST: forward it as a one-flit packet, set proto_err=1, rr_ptr = sel+1 mod NUM_PORTS, stay IDLE.
- State LOCKED (owner k):
  - in_ready = grant & {NUM_PORTS{load_en}}; other ports are held off even when valid.
  - Accepted PAYLOAD: stay LOCKED.
  - Accepted LAST: go to IDLE, grant=0, rr_ptr=(k+1) mod NUM_PORTS.
  - Accepted HEADER or SINGLE: forward it, set proto_err=1, stay LOCKED on k.
  - Owner dropping in_valid mid-packet does not release the lock.
- Simultaneous events:
  - A new packet can be selected in the cycle right after LAST is accepted. No bubble is required beyond the output register.
  - rr_ptr changes only at packet end.
  - Round-robin guarantees each requester waits at most NUM_PORTS-1 packets.
- Throughput: one flit per cycle with out_ready held at 1.
- Latency: in_valid&&in_ready at edge n gives out_valid at edge n+1.
- proto_err clears only on reset.
- Reset mid-packet: the lock, the output flit and rr_ptr are discarded immediately. After reset, arbitration restarts at port 0.
- Inputs must not be X while in_valid=1.

Test Plan:
- Port 1 sends SINGLE 0x3_DEADBEEF, out_ready=1:
  - in_ready[1]=1 in the same cycle; out_flit=0x3DEADBEEF, out_valid=1 one cycle later.
  - grant stays 0; rr_ptr becomes 2.
- Ports 0 and 2 each present a 3-flit packet (HEADER, PAYLOAD, LAST) simultaneously after reset:
  - Port 0's 3 flits appear back-to-back, then port 2's 3 flits with no idle cycle.
  - grant=001 during port 0's packet, then 100.
- Backpressure: hold out_ready=0 for 4 cycles mid-packet:
  - out_flit remains stable and in_ready=0 during the stall.
  - No flit is lost or duplicated; the sequence resumes on out_ready=1.
- Three ports issue continuous SINGLE flits for 12 cycles: output source order is 0,1,2,0,1,2,... and each port gets exactly 4 grants.
- Port 0 sends PAYLOAD while IDLE: the flit is forwarded, proto_err=1 and stays 1 after later legal traffic.
- Port 1 HEADER accepted, then rst=0 asynchronously before its LAST:
  - out_valid=0, grant=0 and in_ready=0 immediately.
  - After release, a port 2 SINGLE is granted without waiting for port 1.

Source files
------------

// File: rtl/noc_packet_arbiter_if.sv
// Link-side bundle of the packet arbiter: requester flits in, one LISNoC flit stream out.
// Handshake: a flit moves on a rising edge where valid && ready; valid must not depend on ready.
interface noc_packet_arbiter_if #(
    parameter int FLIT_DATA_WIDTH = 32,
    parameter int FLIT_TYPE_WIDTH = 2,
    parameter int NUM_PORTS       = 3
);
    localparam int FLIT_WIDTH = FLIT_DATA_WIDTH + FLIT_TYPE_WIDTH;
    localparam int PTR_WIDTH  = $clog2(NUM_PORTS);

    logic [NUM_PORTS*FLIT_WIDTH-1:0] in_flit;
    logic [NUM_PORTS-1:0]            in_valid;
    logic [NUM_PORTS-1:0]            in_ready;
    logic [FLIT_WIDTH-1:0]           out_flit;
    logic                            out_valid;
    logic                            out_ready;
    logic [NUM_PORTS-1:0]            grant;
    logic                            proto_err;
    logic                            dbg_state;
    logic [PTR_WIDTH-1:0]            dbg_rr_ptr;

    modport master (
        input  in_flit, in_valid, out_ready,
        output in_ready, out_flit, out_valid, grant, proto_err, dbg_state, dbg_rr_ptr
    );

    modport slave (
        output in_flit, in_valid, out_ready,
        input  in_ready, out_flit, out_valid, grant, proto_err, dbg_state, dbg_rr_ptr
    );
endinterface

// File: rtl/noc_packet_arbiter.sv
// Packet-atomic round-robin arbiter sharing one LISNoC link between NUM_PORTS sources,
// with a registered full-throughput output stage.
module noc_packet_arbiter #(
    parameter int FLIT_DATA_WIDTH = 32,
    parameter int FLIT_TYPE_WIDTH = 2,
    parameter int NUM_PORTS       = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    noc_packet_arbiter_if.master bus
);
    localparam int FW = FLIT_DATA_WIDTH + FLIT_TYPE_WIDTH;
    localparam int PW = $clog2(NUM_PORTS);
    localparam logic [PW:0] NP = (PW+1)'(NUM_PORTS);

    localparam logic [1:0] T_PAYLOAD = 2'b00;
    localparam logic [1:0] T_HEADER  = 2'b01;
    localparam logic [1:0] T_LAST    = 2'b10;

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]        owner_q, owner_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic                 proto_err_q, proto_err_d;
    logic                 out_valid_q;
    logic [FW-1:0]        out_flit_q;

    logic                 load_en, found, xfer;
    logic [PW-1:0]        sel, xfer_port;
    logic [NUM_PORTS-1:0] ready;
    logic [FW-1:0]        xfer_flit;
    logic [1:0]           xfer_type;

    function automatic logic [PW-1:0] next_port(input logic [PW-1:0] p);
        logic [PW:0] t;
        t = {1'b0, p} + (PW+1)'(1);
        if (t >= NP) t = '0;
        return t[PW-1:0];
    endfunction

    // First valid requester at or after rr_ptr, wrapping modulo NUM_PORTS.
    always_comb begin
        int idx;
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (!found && bus.in_valid[idx]) begin
                found = 1'b1;
                sel   = PW'(idx);
            end
        end
    end

    always_comb begin
        load_en     = !out_valid_q || bus.out_ready;
        ready       = '0;
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        grant_d     = grant_q;
        proto_err_d = proto_err_q;

        if (rst) begin
            if (state_q == LOCKED) ready = grant_q & {NUM_PORTS{load_en}};
            else if (found && load_en) ready[sel] = 1'b1;
        end

        xfer_port = (state_q == LOCKED) ? owner_q : sel;
        xfer      = |(bus.in_valid & ready);
        xfer_flit = bus.in_flit[xfer_port*FW +: FW];
        xfer_type = xfer_flit[FW-1 -: 2];

        if (xfer) begin
            if (state_q == IDLE) begin
                if (xfer_type == T_HEADER) begin
                    state_d      = LOCKED;
                    owner_d      = sel;
                    grant_d      = '0;
                    grant_d[sel] = 1'b1;
                end else begin
                    // SINGLE, or a stray PAYLOAD/LAST forwarded as a one-flit packet
                    if (xfer_type != 2'b11) proto_err_d = 1'b1;
                    rr_ptr_d = next_port(sel);
                end
            end else begin
                if (xfer_type == T_LAST) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    rr_ptr_d = next_port(owner_q);
                end else if (xfer_type != T_PAYLOAD) begin
                    proto_err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            grant_q     <= '0;
            proto_err_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_flit_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            grant_q     <= grant_d;
            proto_err_q <= proto_err_d;
            if (load_en) begin
                out_valid_q <= xfer;
                if (xfer) out_flit_q <= xfer_flit;
            end
        end
    end

    assign bus.in_ready   = ready;
    assign bus.out_flit   = out_flit_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.grant      = grant_q;
    assign bus.proto_err  = proto_err_q;
    assign bus.dbg_state  = state_q;
    assign bus.dbg_rr_ptr = rr_ptr_q;
endmodule

// File: tb/tb_noc_packet_arbiter.sv
// Bench for noc_packet_arbiter: queue-fed sources per port, expected-flit scoreboard on the link.
module tb_noc_packet_arbiter;
  localparam int FW = 34;
  localparam int NP = 3;

  logic clk;
  logic rst;

  noc_packet_arbiter_if #(.FLIT_DATA_WIDTH(32), .FLIT_TYPE_WIDTH(2), .NUM_PORTS(NP)) tb_if ();

  noc_packet_arbiter #(.FLIT_DATA_WIDTH(32), .FLIT_TYPE_WIDTH(2), .NUM_PORTS(NP)) dut (
    .clk(clk),
    .rst(rst),
    .bus(tb_if.master)
  );

  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] src_q[NP][$];
  logic [FW-1:0] mon_exp;
  logic [NP-1:0] acc;
  int            acc_cnt[NP];
  int            checks = 0;
  int            failures = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [31:0] d);
    return {t, d};
  endfunction

  // Scoreboard: every flit the link hands over must be the next expected one.
  always @(negedge clk) begin
    if (rst && tb_if.out_valid && tb_if.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected got=%h", tb_if.out_flit);
      end else begin
        mon_exp = exp_q.pop_front();
        if (tb_if.out_flit !== mon_exp) begin
          failures++;
          $display("FAIL sb_flit got=%h exp=%h", tb_if.out_flit, mon_exp);
        end
      end
    end
  end

  task automatic drive_inputs();
    for (int i = 0; i < NP; i++) begin
      if (src_q[i].size() > 0) begin
        tb_if.in_valid[i] = 1'b1;
        tb_if.in_flit[i*FW +: FW] = src_q[i][0];
      end else begin
        tb_if.in_valid[i] = 1'b0;
        tb_if.in_flit[i*FW +: FW] = '0;
      end
    end
  endtask

  // Called at a negedge: note accepted flits, cross the posedge, advance sources.
  task automatic step();
    acc = tb_if.in_valid & tb_if.in_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NP; i++) begin
      if (acc[i]) begin
        void'(src_q[i].pop_front());
        acc_cnt[i]++;
      end
    end
    drive_inputs();
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < NP; i++) begin
      src_q[i].delete();
      acc_cnt[i] = 0;
    end
    drive_inputs();
    tb_if.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    drive_inputs();
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      step();
      n++;
    end
    repeat (2) begin
      @(negedge clk);
      step();
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain left=%0d exp=0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tb_if.out_ready = 1'b1;
    tb_if.in_valid = '1;
    tb_if.in_flit = {3{mk(2'b11, 32'h0)}};
    @(negedge clk);
    checks++; if (tb_if.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", tb_if.out_valid); end
    checks++; if (tb_if.out_flit !== '0) begin failures++; $display("FAIL rst_out_flit got=%h exp=0", tb_if.out_flit); end
    checks++; if (tb_if.grant !== 3'b000) begin failures++; $display("FAIL rst_grant got=%b exp=000", tb_if.grant); end
    checks++; if (tb_if.proto_err !== 1'b0) begin failures++; $display("FAIL rst_proto_err got=%b exp=0", tb_if.proto_err); end
    checks++; if (tb_if.in_ready !== 3'b000) begin failures++; $display("FAIL rst_in_ready got=%b exp=000", tb_if.in_ready); end
    checks++; if (tb_if.dbg_state !== 1'b0 || tb_if.dbg_rr_ptr !== 2'd0) begin failures++; $display("FAIL rst_state got=%b/%0d exp=0/0", tb_if.dbg_state, tb_if.dbg_rr_ptr); end
    reset_dut();
  endtask

  task automatic test_single();
    logic [FW-1:0] f;
    reset_dut();
    f = mk(2'b11, 32'hDEADBEEF);
    src_q[1].push_back(f);
    exp_q.push_back(f);
    drive_inputs();
    @(negedge clk);
    checks++; if (tb_if.in_ready !== 3'b010) begin failures++; $display("FAIL single_in_ready got=%b exp=010", tb_if.in_ready); end
    step();
    @(negedge clk);
    checks++; if (tb_if.out_valid !== 1'b1 || tb_if.out_flit !== 34'h3DEADBEEF) begin failures++; $display("FAIL single_out got=%b/%h exp=1/3deadbeef", tb_if.out_valid, tb_if.out_flit); end
    checks++; if (tb_if.grant !== 3'b000) begin failures++; $display("FAIL single_grant got=%b exp=000", tb_if.grant); end
    checks++; if (tb_if.dbg_rr_ptr !== 2'd2) begin failures++; $display("FAIL single_rr_ptr got=%0d exp=2", tb_if.dbg_rr_ptr); end
    step();
    drain("single");
  endtask

  task automatic test_two_packets();
    logic [2:0] g_tab [7];
    logic [2:0] r_tab [7];
    logic       v_tab [7];
    g_tab = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b100, 3'b100, 3'b000};
    r_tab = '{3'b001, 3'b001, 3'b001, 3'b100, 3'b100, 3'b100, 3'b000};
    v_tab = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    reset_dut();
    for (int p = 0; p < NP; p += 2) begin
      src_q[p].push_back(mk(2'b01, 32'hA000_0000 + p));
      src_q[p].push_back(mk(2'b00, 32'hA000_0010 + p));
      src_q[p].push_back(mk(2'b10, 32'hA000_0020 + p));
    end
    for (int p = 0; p < NP; p += 2)
      for (int k = 0; k < 3; k++) exp_q.push_back(src_q[p][k]);
    drive_inputs();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      checks++; if (tb_if.grant !== g_tab[c]) begin failures++; $display("FAIL pkt_grant c=%0d got=%b exp=%b", c, tb_if.grant, g_tab[c]); end
      checks++; if (tb_if.in_ready !== r_tab[c]) begin failures++; $display("FAIL pkt_in_ready c=%0d got=%b exp=%b", c, tb_if.in_ready, r_tab[c]); end
      checks++; if (tb_if.out_valid !== v_tab[c]) begin failures++; $display("FAIL pkt_out_valid c=%0d got=%b exp=%b", c, tb_if.out_valid, v_tab[c]); end
      step();
    end
    drain("pkt");
  endtask

  task automatic test_backpressure();
    logic [FW-1:0] p1;
    reset_dut();
    p1 = mk(2'b00, 32'hB000_0001);
    src_q[0].push_back(mk(2'b01, 32'hB000_0000));
    src_q[0].push_back(p1);
    src_q[0].push_back(mk(2'b00, 32'hB000_0002));
    src_q[0].push_back(mk(2'b00, 32'hB000_0003));
    src_q[0].push_back(mk(2'b10, 32'hB000_0004));
    for (int k = 0; k < 5; k++) exp_q.push_back(src_q[0][k]);
    drive_inputs();
    repeat (2) begin
      @(negedge clk);
      step();
    end
    tb_if.out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (tb_if.out_valid !== 1'b1 || tb_if.out_flit !== p1) begin failures++; $display("FAIL bp_hold c=%0d got=%b/%h exp=1/%h", c, tb_if.out_valid, tb_if.out_flit, p1); end
      checks++; if (tb_if.in_ready !== 3'b000) begin failures++; $display("FAIL bp_in_ready c=%0d got=%b exp=000", c, tb_if.in_ready); end
      step();
    end
    tb_if.out_ready = 1'b1;
    drain("bp");
    checks++; if (acc_cnt[0] != 5) begin failures++; $display("FAIL bp_accepts got=%0d exp=5", acc_cnt[0]); end
  endtask

  task automatic test_round_robin();
    reset_dut();
    for (int k = 0; k < 4; k++)
      for (int p = 0; p < NP; p++) begin
        src_q[p].push_back(mk(2'b11, 32'hC000_0000 + (p << 8) + k));
        exp_q.push_back(mk(2'b11, 32'hC000_0000 + (p << 8) + k));
      end
    drive_inputs();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++; if (tb_if.in_ready !== NP'(1 << (c % NP))) begin failures++; $display("FAIL rr_in_ready c=%0d got=%b exp=%b", c, tb_if.in_ready, NP'(1 << (c % NP))); end
      step();
    end
    drain("rr");
    for (int p = 0; p < NP; p++) begin
      checks++; if (acc_cnt[p] != 4) begin failures++; $display("FAIL rr_count p=%0d got=%0d exp=4", p, acc_cnt[p]); end
    end
  endtask

  task automatic test_proto_err();
    reset_dut();
    src_q[0].push_back(mk(2'b00, 32'h0000_1234));
    exp_q.push_back(mk(2'b00, 32'h0000_1234));
    drive_inputs();
    @(negedge clk);
    checks++; if (tb_if.in_ready !== 3'b001) begin failures++; $display("FAIL perr_in_ready got=%b exp=001", tb_if.in_ready); end
    step();
    @(negedge clk);
    checks++; if (tb_if.proto_err !== 1'b1) begin failures++; $display("FAIL perr_set got=%b exp=1", tb_if.proto_err); end
    checks++; if (tb_if.grant !== 3'b000 || tb_if.dbg_rr_ptr !== 2'd1) begin failures++; $display("FAIL perr_arb got=%b/%0d exp=000/1", tb_if.grant, tb_if.dbg_rr_ptr); end
    step();
    src_q[1].push_back(mk(2'b11, 32'h0000_5678));
    exp_q.push_back(mk(2'b11, 32'h0000_5678));
    drive_inputs();
    drain("perr");
    checks++; if (tb_if.proto_err !== 1'b1) begin failures++; $display("FAIL perr_sticky got=%b exp=1", tb_if.proto_err); end
  endtask

  task automatic test_reset_mid_packet();
    logic [FW-1:0] s2;
    reset_dut();
    s2 = mk(2'b11, 32'hE000_0002);
    src_q[1].push_back(mk(2'b01, 32'hE000_0001));
    src_q[1].push_back(mk(2'b00, 32'hE000_0011));
    exp_q.push_back(src_q[1][0]);
    drive_inputs();
    @(negedge clk);
    step();
    @(negedge clk);
    checks++; if (tb_if.grant !== 3'b010) begin failures++; $display("FAIL mid_grant got=%b exp=010", tb_if.grant); end
    step();
    rst = 1'b0;
    #1;
    checks++; if (tb_if.out_valid !== 1'b0 || tb_if.grant !== 3'b000) begin failures++; $display("FAIL mid_async got=%b/%b exp=0/000", tb_if.out_valid, tb_if.grant); end
    checks++; if (tb_if.dbg_state !== 1'b0 || tb_if.dbg_rr_ptr !== 2'd0) begin failures++; $display("FAIL mid_state got=%b/%0d exp=0/0", tb_if.dbg_state, tb_if.dbg_rr_ptr); end
    src_q[2].push_back(s2);
    drive_inputs();
    #1;
    checks++; if (tb_if.in_ready !== 3'b000) begin failures++; $display("FAIL mid_in_ready_rst got=%b exp=000", tb_if.in_ready); end
    exp_q.push_back(s2);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checks++; if (tb_if.in_ready !== 3'b100) begin failures++; $display("FAIL mid_restart got=%b exp=100", tb_if.in_ready); end
    step();
    @(negedge clk);
    checks++; if (tb_if.out_valid !== 1'b1 || tb_if.out_flit !== s2 || tb_if.grant !== 3'b000) begin failures++; $display("FAIL mid_out got=%b/%h/%b exp=1/%h/000", tb_if.out_valid, tb_if.out_flit, tb_if.grant, s2); end
    step();
    drain("mid");
  endtask

  initial begin
    rst = 1'b0;
    tb_if.in_valid = '0;
    tb_if.in_flit = '0;
    tb_if.out_ready = 1'b1;
    test_reset();
    test_single();
    test_two_packets();
    test_backpressure();
    test_round_robin();
    test_proto_err();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
